// File: rtl/bt656_video_out_encoder.sv
// bt656_video_out_encoder
//
// Serialises a 4:2:2 YCbCr pixel stream (one pixel per valid/ready beat,
// data = {C, Y}) into an 8-bit ITU-R BT.656 525-line interlaced byte stream.
// EAV/SAV timing codes (with protection bits) and blanking fill are inserted.
// The encoder passes chroma through in beat order (Cb Y Cr Y) and does not
// reorder it.
//
// Ports:
//   clk                   video clock (27 MHz), rising edge
//   reset                 synchronous, active-high
//   stream_data[15:0]     {C, Y}; C is Cb on even pixels, Cr on odd pixels
//   stream_startofpacket  first pixel of a field
//   stream_valid          beat valid
//   stream_ready          beat accepted when valid && ready (combinational)
//   bt656_data[7:0]       BT.656 byte stream (registered)
//   field                 current F bit, aligned with bt656_data
//   underflow             sticky; a locked pixel was filled for lack of data
//   hsync_n, vsync_n      only with BT656_SYNC_OUT_EN defined; registered and
//                         aligned with bt656_data
//
// Optional feature macro: BT656_SYNC_OUT_EN
//
// state  | meaning
// SEEK   | not aligned to a field; discard non-sop beats, hold a sop beat
//        | until the first active pixel of the next V=0 region
// LOCKED | one beat consumed per C-slot; missing beats become fill

module bt656_video_out_encoder #(
  parameter int         H_ACTIVE = 720,
  parameter int         H_BLANK  = 268,
  parameter logic [7:0] BLANK_Y  = 8'h10,
  parameter logic [7:0] BLANK_C  = 8'h80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] stream_data,
  input  logic        stream_startofpacket,
  input  logic        stream_valid,
  output logic        stream_ready,
  output logic [7:0]  bt656_data,
  output logic        field,
`ifdef BT656_SYNC_OUT_EN
  output logic        hsync_n,
  output logic        vsync_n,
`endif
  output logic        underflow
);

  localparam int L  = 8 + H_BLANK + 2 * H_ACTIVE;
  localparam int HW = $clog2(L);

  localparam logic [HW-1:0] H_LAST = HW'(L - 1);
  localparam logic [HW-1:0] H_BLK0 = HW'(4);
  localparam logic [HW-1:0] H_SAV0 = HW'(H_BLANK + 4);
  localparam logic [HW-1:0] H_ACT0 = HW'(H_BLANK + 8);

  typedef enum logic {SEEK, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] h;
  logic [9:0]    ln;
  logic [7:0]    y_hold;

  logic       v_flag, f_flag, h_flag;
  logic       in_active, c_byte, c_slot, first_pix;
  logic       take, uf_set, ready_c;
  logic [1:0] tc_idx;
  logic [7:0] xy, byte_nxt;

  assign v_flag    = (ln <= 10'd19) || (ln >= 10'd264 && ln <= 10'd282);
  assign f_flag    = (ln <= 10'd3) || (ln >= 10'd266);
  assign h_flag    = (h < H_SAV0);
  assign in_active = (h >= H_ACT0);
  // Active bytes alternate C,Y starting at H_ACT0.
  assign c_byte    = (h[0] == H_ACT0[0]);
  assign c_slot    = in_active && !v_flag && c_byte;
  // First active pixel of each field's V=0 region.
  assign first_pix = (h == H_ACT0) && (ln == 10'd20 || ln == 10'd283);

  assign xy = {1'b1, f_flag, v_flag, h_flag, v_flag ^ h_flag,
               f_flag ^ h_flag, f_flag ^ v_flag, f_flag ^ v_flag ^ h_flag};
  assign tc_idx = h_flag ? h[1:0] : 2'(h - H_SAV0);

  assign stream_ready = ready_c;

  // Position counters
  always_ff @(posedge clk) begin
    if (reset) begin
      h  <= '0;
      ln <= 10'd1;
    end else if (h == H_LAST) begin
      h  <= '0;
      ln <= (ln == 10'd525) ? 10'd1 : ln + 10'd1;
    end else begin
      h <= h + HW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= SEEK;
    else       state <= state_nxt;
  end

  // FSM next state and handshake; only C-slots can consume a beat
  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    take      = 1'b0;
    uf_set    = 1'b0;
    if (!reset && c_slot) begin
      unique case (state)
        SEEK: begin
          if (stream_valid) begin
            if (!stream_startofpacket) begin
              ready_c = 1'b1;
            end else if (first_pix) begin
              ready_c   = 1'b1;
              take      = 1'b1;
              state_nxt = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (!stream_valid) begin
            uf_set = 1'b1;
          end else if (first_pix != stream_startofpacket) begin
            // sop mid-field is held for re-alignment; a non-sop beat at
            // the field start means the source lost alignment
            state_nxt = SEEK;
          end else begin
            ready_c = 1'b1;
            take    = 1'b1;
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
  end

  // Byte selection for the current position
  always_comb begin
    byte_nxt = BLANK_C;
    if (h < H_BLK0 || (h >= H_SAV0 && !in_active)) begin
      unique case (tc_idx)
        2'd0:    byte_nxt = 8'hFF;
        2'd3:    byte_nxt = xy;
        default: byte_nxt = 8'h00;
      endcase
    end else if (!in_active) begin
      byte_nxt = h[0] ? BLANK_Y : BLANK_C;
    end else if (v_flag) begin
      byte_nxt = c_byte ? BLANK_C : BLANK_Y;
    end else if (c_byte) begin
      byte_nxt = take ? stream_data[15:8] : BLANK_C;
    end else begin
      byte_nxt = y_hold;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bt656_data <= BLANK_C;
      field      <= 1'b1;
      underflow  <= 1'b0;
      y_hold     <= BLANK_Y;
    end else begin
      bt656_data <= byte_nxt;
      field      <= f_flag;
      if (uf_set) underflow <= 1'b1;
      // Y of a pixel follows its C byte; unfilled pixels get blank luma
      if (c_slot) y_hold <= take ? stream_data[7:0] : BLANK_Y;
    end
  end

`ifdef BT656_SYNC_OUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_n <= 1'b1;
      vsync_n <= 1'b1;
    end else begin
      hsync_n <= in_active;
      vsync_n <= !v_flag;
    end
  end
`endif

endmodule

// File: tb/tb_bt656_video_out_encoder.sv
module tb_bt656_video_out_encoder;

  // Short lines keep several frames well inside the cycle budget.
  localparam int HA = 8;
  localparam int HB = 8;
  localparam int L  = 8 + HB + 2 * HA;  // 32; active bytes at h 16..31

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] stream_data = '0;
  logic        stream_startofpacket = 1'b0;
  logic        stream_valid = 1'b0;
  logic        stream_ready;
  logic [7:0]  bt656_data;
  logic        field;
  logic        underflow;
`ifdef BT656_SYNC_OUT_EN
  logic        hsync_n;
  logic        vsync_n;
`endif

  always #5 clk = ~clk;

  bt656_video_out_encoder #(.H_ACTIVE(HA), .H_BLANK(HB)) dut (
    .clk                  (clk),
    .reset                (reset),
    .stream_data          (stream_data),
    .stream_startofpacket (stream_startofpacket),
    .stream_valid         (stream_valid),
    .stream_ready         (stream_ready),
    .bt656_data           (bt656_data),
    .field                (field),
`ifdef BT656_SYNC_OUT_EN
    .hsync_n              (hsync_n),
    .vsync_n              (vsync_n),
`endif
    .underflow            (underflow)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // cur_*: position held by the DUT counters; out_*: position of the byte
  // currently on bt656_data.
  int cur_h = 0, cur_ln = 1, out_h = -1, out_ln = -1;
  int src_k = 0, sop_b = -1, drop_ln = 0, drop_h = 0;
  int count_ln = 0, acc_line = 0, acc_total = 0;
  bit src_on = 1'b0, last_ready = 1'b0, rdy_seen = 1'b0;
  logic [7:0] line_buf [0:31];
  logic [7:0] kk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive source, sample handshake, advance the position model.
  task automatic cyc();
    logic acc;
    stream_valid         = src_on && !(cur_ln == drop_ln && cur_h == drop_h);
    stream_data          = {src_k[7:0], ~src_k[7:0]};
    stream_startofpacket = (src_k == 0) || (src_k == sop_b);
    #1;
    last_ready = stream_ready;
    rdy_seen   = rdy_seen | stream_ready;
    acc        = stream_valid && stream_ready;
    if (acc) begin
      acc_total++;
      if (cur_ln == count_ln) acc_line++;
    end
    @(posedge clk);
    #1;
    out_h  = cur_h;
    out_ln = cur_ln;
    if (cur_h == L - 1) begin
      cur_h  = 0;
      cur_ln = (cur_ln == 525) ? 1 : cur_ln + 1;
    end else begin
      cur_h++;
    end
    if (acc) src_k++;
  endtask

  task automatic run_to(input int l, input int hh);
    int n = 0;
    while (!(out_ln == l && out_h == hh) && n < 20000) begin
      cyc();
      n++;
    end
    check("reach_position", {15'd0, n < 20000}, 16'd1);
  endtask

  initial begin
    // ---- reset state ----
    reset = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("rst_data", bt656_data, 16'h80);
    check("rst_ready", stream_ready, 16'd0);
    check("rst_field", field, 16'd1);
    check("rst_underflow", underflow, 16'd0);
`ifdef BT656_SYNC_OUT_EN
    check("rst_hsync", hsync_n, 16'd1);
    check("rst_vsync", vsync_n, 16'd1);
`endif
    reset = 1'b0;
    cur_h = 0;
    cur_ln = 1;

    // ---- line 1 with no source ----
    for (int i = 0; i < L; i++) begin
      cyc();
      line_buf[i] = bt656_data;
`ifdef BT656_SYNC_OUT_EN
      if (i == 15) check("hsync_sav_end", hsync_n, 16'd0);
      if (i == 16) check("hsync_active", hsync_n, 16'd1);
      if (i == 16) check("vsync_ln1", vsync_n, 16'd0);
`endif
    end
    check("l1_eav0", line_buf[0], 16'hFF);
    check("l1_eav1", line_buf[1], 16'h00);
    check("l1_eav2", line_buf[2], 16'h00);
    check("l1_eav3", line_buf[3], 16'hF1);
    check("l1_blank4", line_buf[4], 16'h80);
    check("l1_blank5", line_buf[5], 16'h10);
    check("l1_sav0", line_buf[12], 16'hFF);
    check("l1_sav1", line_buf[13], 16'h00);
    check("l1_sav2", line_buf[14], 16'h00);
    check("l1_sav3", line_buf[15], 16'hEC);
    check("l1_vact_c", line_buf[16], 16'h80);
    check("l1_vact_y", line_buf[31], 16'h10);
    check("l1_ready_low", {15'd0, rdy_seen}, 16'd0);
    check("l1_underflow", underflow, 16'd0);

    // ---- free run through the flag boundaries ----
    run_to(4, 3);
    check("ln4_eav", bt656_data, 16'hB6);
    check("ln4_field", field, 16'd0);
    run_to(20, 3);
    check("ln20_eav", bt656_data, 16'h9D);
    check("ln20_field", field, 16'd0);
`ifdef BT656_SYNC_OUT_EN
    check("vsync_ln20", vsync_n, 16'd1);
`endif
    run_to(20, 15);
    check("ln20_sav", bt656_data, 16'h80);
    run_to(265, 3);
    check("ln265_eav", bt656_data, 16'hB6);
    run_to(266, 3);
    check("ln266_eav", bt656_data, 16'hF1);
    check("ln266_field", field, 16'd1);
    run_to(283, 3);
    check("ln283_eav", bt656_data, 16'hDA);
    run_to(525, 3);
    check("ln525_eav", bt656_data, 16'hDA);
    run_to(1, 3);
    check("wrap_ln1_eav", bt656_data, 16'hF1);
    check("free_underflow", underflow, 16'd0);

    // ---- stream a field: beat k = {k, ~k}, sop on k=0 ----
    src_on   = 1'b1;
    count_ln = 20;
    acc_line = 0;
    run_to(20, 15);
    for (int i = 0; i < 2 * HA; i++) begin
      cyc();
      kk = 8'(i / 2);
      check("ln20_active", bt656_data, {8'd0, i[0] ? ~kk : kk});
    end
    check("ln20_beats", 16'(acc_line), 16'd8);
    count_ln = 21;
    acc_line = 0;
    run_to(21, 31);
    check("ln21_beats", 16'(acc_line), 16'd8);
    check("stream_underflow", underflow, 16'd0);

    // ---- drop valid for pixel 5 of line 30 (C-slot h=26) ----
    drop_ln = 30;
    drop_h  = 26;
    run_to(30, 25);
    check("pre_drop_underflow", underflow, 16'd0);
    cyc();
    check("drop_c", bt656_data, 16'h80);
    cyc();
    check("drop_y", bt656_data, 16'h10);
    check("drop_underflow", underflow, 16'd1);
    cyc();
    check("after_drop_c", bt656_data, 16'h55);
    cyc();
    check("after_drop_y", bt656_data, 16'hAA);

    // ---- sop at pixel 3 of line 40 while locked (beat 162) ----
    sop_b = 162;
    run_to(40, 21);
    acc_total = 0;
    cyc();
    check("midsop_ready", {15'd0, last_ready}, 16'd0);
    check("midsop_fill_c", bt656_data, 16'h80);
    cyc();
    check("midsop_fill_y", bt656_data, 16'h10);
    run_to(283, 15);
    check("held_no_accept", 16'(acc_total), 16'd0);
    cyc();
    check("field_start_ready", {15'd0, last_ready}, 16'd1);
    check("field_start_c", bt656_data, 16'hA2);
    check("field_start_field", field, 16'd1);
    cyc();
    check("field_start_y", bt656_data, 16'h5D);
    cyc();
    check("field_next_c", bt656_data, 16'hA3);
    check("sticky_underflow", underflow, 16'd1);

    // ---- frame 3: non-sop at ln 20 forces SEEK, beats discarded ----
    run_to(100, 17);
    cyc();
    check("seek_discard_ready", {15'd0, last_ready}, 16'd1);
    cyc();
    check("pre_reset_underflow", underflow, 16'd1);

    // ---- reset at h=20 of ln 100 (a C-slot, beat pending) ----
    reset = 1'b1;
    cyc();
    check("midreset_ready", {15'd0, last_ready}, 16'd0);
    check("midreset_data", bt656_data, 16'h80);
    check("midreset_field", field, 16'd1);
    check("midreset_underflow", underflow, 16'd0);
    reset  = 1'b0;
    src_on = 1'b0;
    cur_h  = 0;
    cur_ln = 1;
    cyc();
    check("post_reset_eav0", bt656_data, 16'hFF);
    cyc();
    cyc();
    cyc();
    check("post_reset_eav3", bt656_data, 16'hF1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
